rf_ctrl: RTL and testbench

RF_CTRL -- requirements
Module: rf_ctrl

---
 rtl/rf_ctrl.sv | 149 ++++++++++++++
 tb/tb_rf_ctrl.sv | 281 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/rf_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : rf_ctrl
// Description : Two-requester round-robin command controller for a register
//               file. Supports WRITE, READ and CLEAR (sweep) commands.
// Revision    : 1.0 - initial release
// ============================================================================
module rf_ctrl #(
    parameter int N = 4,
    parameter int W = 8
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         req0_valid,
    output logic         req0_ready,
    input  logic [1:0]   req0_op,
    input  logic [N-1:0] req0_addr,
    input  logic [W-1:0] req0_data,
    input  logic         req1_valid,
    output logic         req1_ready,
    input  logic [1:0]   req1_op,
    input  logic [N-1:0] req1_addr,
    input  logic [W-1:0] req1_data,
    output logic         resp_valid,
    output logic         resp_id,
    output logic [W-1:0] resp_data,
    output logic         resp_err,
    output logic         busy,
    output logic         rf_we,
    output logic [N-1:0] rf_addr_rd,
    output logic [W-1:0] rf_data_in,
    output logic [N-1:0] rf_addr_rs1,
    input  logic [W-1:0] rf_rs1
);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        EXEC  = 2'd1,
        SWEEP = 2'd2,
        RESP  = 2'd3
    } state_t;

    localparam logic [1:0]   c_OP_WRITE = 2'b00;
    localparam logic [1:0]   c_OP_READ  = 2'b01;
    localparam logic [1:0]   c_OP_CLEAR = 2'b10;
    localparam logic [1:0]   c_OP_RSVD  = 2'b11;
    localparam logic [N-1:0] c_ADDR_MAX = {N{1'b1}};

    state_t       r_state;
    logic         r_last_grant;
    logic [N-1:0] r_cnt;
    logic [1:0]   r_op;
    logic [N-1:0] r_addr;
    logic [W-1:0] r_data;
    logic         r_id;

    logic         w_idle;
    logic         w_gnt0;
    logic         w_gnt1;
    logic [1:0]   w_op;
    logic [N-1:0] w_addr;
    logic [W-1:0] w_data;
    logic         w_exec_wr;
    logic         w_exec_rd;

    // On a tie the requester that did not win last time gets the grant.
    assign w_idle     = (r_state == IDLE);
    assign w_gnt0     = w_idle && req0_valid && (!req1_valid || r_last_grant);
    assign w_gnt1     = w_idle && req1_valid && (!req0_valid || !r_last_grant);
    assign req0_ready = w_gnt0;
    assign req1_ready = w_gnt1;

    assign w_op   = w_gnt1 ? req1_op   : req0_op;
    assign w_addr = w_gnt1 ? req1_addr : req0_addr;
    assign w_data = w_gnt1 ? req1_data : req0_data;

    // Address 0 is read-only: a WRITE there never reaches the register file.
    assign w_exec_wr = (r_state == EXEC) && (r_op == c_OP_WRITE) && (r_addr != '0);
    assign w_exec_rd = (r_state == EXEC) && (r_op == c_OP_READ);

    assign rf_we       = w_exec_wr || (r_state == SWEEP);
    assign rf_addr_rd  = (r_state == SWEEP) ? r_cnt : (w_exec_wr ? r_addr : '0);
    assign rf_data_in  = w_exec_wr ? r_data : '0;
    assign rf_addr_rs1 = w_exec_rd ? r_addr : '0;
    assign busy        = !w_idle;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state      <= IDLE;
            r_last_grant <= 1'b1;
            r_cnt        <= '0;
            r_op         <= '0;
            r_addr       <= '0;
            r_data       <= '0;
            r_id         <= 1'b0;
            resp_valid   <= 1'b0;
            resp_id      <= 1'b0;
            resp_data    <= '0;
            resp_err     <= 1'b0;
        end else begin
            resp_valid <= 1'b0;
            case (r_state)
                IDLE: begin
                    if (w_gnt0 || w_gnt1) begin
                        r_op         <= w_op;
                        r_addr       <= w_addr;
                        r_data       <= w_data;
                        r_id         <= w_gnt1;
                        r_last_grant <= w_gnt1;
                        if (w_op == c_OP_CLEAR) begin
                            r_cnt   <= N'(1);
                            r_state <= SWEEP;
                        end else begin
                            r_state <= EXEC;
                        end
                    end
                end
                EXEC: begin
                    r_state    <= RESP;
                    resp_valid <= 1'b1;
                    resp_id    <= r_id;
                    resp_data  <= w_exec_rd ? rf_rs1 : '0;
                    resp_err   <= (r_op == c_OP_RSVD) ||
                                  ((r_op == c_OP_WRITE) && (r_addr == '0));
                end
                SWEEP: begin
                    if (r_cnt == c_ADDR_MAX) begin
                        r_cnt      <= '0;
                        r_state    <= RESP;
                        resp_valid <= 1'b1;
                        resp_id    <= r_id;
                        resp_data  <= '0;
                        resp_err   <= 1'b0;
                    end else begin
                        r_cnt <= r_cnt + N'(1);
                    end
                end
                RESP: begin
                    r_state <= IDLE;
                end
                default: begin
                    r_state <= IDLE;
                end
            endcase
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_rf_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : tb_rf_ctrl
// Description : Self-checking bench for rf_ctrl with a behavioural model.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_rf_ctrl;

    localparam int N     = 4;
    localparam int W     = 8;
    localparam int DEPTH = 2 ** N;

    logic         clk = 1'b0;
    logic         rst = 1'b1;
    logic         req0_valid = 1'b0, req1_valid = 1'b0;
    logic         req0_ready, req1_ready;
    logic [1:0]   req0_op = '0, req1_op = '0;
    logic [N-1:0] req0_addr = '0, req1_addr = '0;
    logic [W-1:0] req0_data = '0, req1_data = '0;
    logic         resp_valid, resp_id, resp_err, busy, rf_we;
    logic [W-1:0] resp_data, rf_data_in, rf_rs1;
    logic [N-1:0] rf_addr_rd, rf_addr_rs1;

    int n_checks = 0;
    int n_errors = 0;

    logic [W-1:0] rf_mem [DEPTH];
    logic [W-1:0] mdl    [DEPTH];
    logic         exp_last;
    logic [N-1:0] we_addr_q [$];
    logic [W-1:0] we_data_q [$];
    int           we_k_q    [$];

    rf_ctrl #(.N(N), .W(W)) dut (
        .clk(clk), .rst(rst),
        .req0_valid(req0_valid), .req0_ready(req0_ready), .req0_op(req0_op),
        .req0_addr(req0_addr), .req0_data(req0_data),
        .req1_valid(req1_valid), .req1_ready(req1_ready), .req1_op(req1_op),
        .req1_addr(req1_addr), .req1_data(req1_data),
        .resp_valid(resp_valid), .resp_id(resp_id), .resp_data(resp_data),
        .resp_err(resp_err), .busy(busy), .rf_we(rf_we), .rf_addr_rd(rf_addr_rd),
        .rf_data_in(rf_data_in), .rf_addr_rs1(rf_addr_rs1), .rf_rs1(rf_rs1)
    );

    always #5 clk = ~clk;

    // External register file attached to the controller.
    always @(posedge clk) if (rf_we) rf_mem[rf_addr_rd] <= rf_data_in;
    assign rf_rs1 = rf_mem[rf_addr_rs1];

    task automatic do_reset();
        @(negedge clk);
        rst = 1'b1;
        repeat (2) @(negedge clk);
        rst = 1'b0;
        exp_last = 1'b1;
    endtask

    // Presents one or two requests, waits for the handshake, then logs every
    // cycle up to the response. Cycle k=1 is the cycle after the handshake.
    task automatic run_cmd(input logic v0, input logic v1,
                           input logic [1:0] op0, input logic [1:0] op1,
                           input logic [N-1:0] a0, input logic [N-1:0] a1,
                           input logic [W-1:0] d0, input logic [W-1:0] d1,
                           output logic gid, output int lat, output logic rid,
                           output logic [W-1:0] rdata, output logic rerr,
                           output int busy_cnt, output logic tail_ok);
        logic hs;
        hs = 1'b0; gid = 1'b0; lat = -1; rid = 1'b0; rdata = '0; rerr = 1'b0;
        busy_cnt = 0; tail_ok = 1'b0;
        we_addr_q.delete(); we_data_q.delete(); we_k_q.delete();
        @(negedge clk);
        req0_valid = v0; req0_op = op0; req0_addr = a0; req0_data = d0;
        req1_valid = v1; req1_op = op1; req1_addr = a1; req1_data = d1;
        for (int i = 0; i < 20; i++) begin
            #1;
            if (req0_ready || req1_ready) begin
                hs = 1'b1;
                gid = req1_ready;
                break;
            end
            @(negedge clk);
        end
        @(negedge clk);
        req0_valid = 1'b0; req1_valid = 1'b0;
        req0_op = 2'($urandom); req0_addr = N'($urandom); req0_data = W'($urandom);
        req1_op = 2'($urandom); req1_addr = N'($urandom); req1_data = W'($urandom);
        if (!hs) return;
        for (int k = 1; k <= 40; k++) begin
            #1;
            if (busy) busy_cnt++;
            if (rf_we) begin
                we_addr_q.push_back(rf_addr_rd);
                we_data_q.push_back(rf_data_in);
                we_k_q.push_back(k);
            end
            if (resp_valid) begin
                lat = k; rid = resp_id; rdata = resp_data; rerr = resp_err;
                break;
            end
            @(negedge clk);
        end
        @(negedge clk);
        #1;
        tail_ok = !resp_valid && !busy;
    endtask

    task automatic fill_regs();
        logic g, r, e, t; int l, b; logic [W-1:0] d, rd;
        for (int a = 1; a < DEPTH; a++) begin
            d = W'($urandom_range(1, 255));
            run_cmd(1'b1, 1'b0, 2'b00, 2'b00, N'(a), '0, d, '0, g, l, r, rd, e, b, t);
            mdl[a] = d;
        end
    endtask

    task automatic test_reset();
        do_reset();
        #1;
        n_checks++; if (resp_valid !== 1'b0) begin n_errors++; $display("FAIL reset_resp_valid: got %b exp 0", resp_valid); end
        n_checks++; if (resp_id !== 1'b0) begin n_errors++; $display("FAIL reset_resp_id: got %b exp 0", resp_id); end
        n_checks++; if (resp_data !== '0) begin n_errors++; $display("FAIL reset_resp_data: got %h exp 0", resp_data); end
        n_checks++; if (resp_err !== 1'b0) begin n_errors++; $display("FAIL reset_resp_err: got %b exp 0", resp_err); end
        n_checks++; if (busy !== 1'b0) begin n_errors++; $display("FAIL reset_busy: got %b exp 0", busy); end
        n_checks++; if ({rf_we, rf_addr_rd, rf_data_in, rf_addr_rs1} !== '0) begin n_errors++;
            $display("FAIL reset_rf_port: got we=%b rd=%h din=%h rs1=%h exp all 0", rf_we, rf_addr_rd, rf_data_in, rf_addr_rs1); end
        n_checks++; if ({req0_ready, req1_ready} !== 2'b00) begin n_errors++; $display("FAIL reset_ready: got %b exp 00", {req0_ready, req1_ready}); end
    endtask

    task automatic test_write_read();
        logic g, r, e, t; int l, b; logic [W-1:0] rd; logic ok;
        run_cmd(1'b1, 1'b0, 2'b00, 2'b00, N'(3), '0, 8'hA5, '0, g, l, r, rd, e, b, t);
        mdl[3] = 8'hA5;
        ok = (we_addr_q.size() == 1) && (we_k_q[0] == 1) && (we_addr_q[0] == N'(3)) && (we_data_q[0] == 8'hA5);
        n_checks++; if (!ok) begin n_errors++; $display("FAIL wr_pulse: got %0d writes exp 1 write at k=1 addr 3 data a5", we_addr_q.size()); end
        n_checks++; if (l !== 2 || r !== 1'b0 || e !== 1'b0) begin n_errors++; $display("FAIL wr_resp: got lat=%0d id=%b err=%b exp lat=2 id=0 err=0", l, r, e); end
        run_cmd(1'b0, 1'b1, 2'b00, 2'b01, '0, N'(3), '0, '0, g, l, r, rd, e, b, t);
        n_checks++; if (l !== 2 || r !== 1'b1 || rd !== 8'hA5 || e !== 1'b0) begin n_errors++;
            $display("FAIL rd_resp: got lat=%0d id=%b data=%h err=%b exp lat=2 id=1 data=a5 err=0", l, r, rd, e); end
        n_checks++; if (t !== 1'b1) begin n_errors++; $display("FAIL rd_tail: got %b exp 1 (resp one cycle, back to idle)", t); end
    endtask

    task automatic test_addr0();
        logic g, r, e, t; int l, b; logic [W-1:0] rd;
        run_cmd(1'b1, 1'b0, 2'b00, 2'b00, '0, '0, 8'hFF, '0, g, l, r, rd, e, b, t);
        n_checks++; if (we_addr_q.size() != 0) begin n_errors++; $display("FAIL wr0_we: got %0d writes exp 0", we_addr_q.size()); end
        n_checks++; if (l !== 2 || e !== 1'b1 || rd !== '0) begin n_errors++; $display("FAIL wr0_resp: got lat=%0d err=%b data=%h exp lat=2 err=1 data=0", l, e, rd); end
        run_cmd(1'b1, 1'b0, 2'b01, 2'b00, '0, '0, '0, '0, g, l, r, rd, e, b, t);
        n_checks++; if (l !== 2 || e !== 1'b0 || rd !== '0) begin n_errors++; $display("FAIL rd0_resp: got lat=%0d err=%b data=%h exp lat=2 err=0 data=0", l, e, rd); end
    endtask

    task automatic test_reserved();
        logic g, r, e, t; int l, b; logic [W-1:0] rd;
        run_cmd(1'b0, 1'b1, 2'b00, 2'b11, '0, N'($urandom_range(1, DEPTH-1)), '0, W'($urandom), g, l, r, rd, e, b, t);
        n_checks++; if (we_addr_q.size() != 0) begin n_errors++; $display("FAIL rsvd_we: got %0d writes exp 0", we_addr_q.size()); end
        n_checks++; if (l !== 2 || e !== 1'b1 || rd !== '0 || r !== 1'b1) begin n_errors++;
            $display("FAIL rsvd_resp: got lat=%0d err=%b data=%h id=%b exp lat=2 err=1 data=0 id=1", l, e, rd, r); end
    endtask

    task automatic test_clear();
        logic g, r, e, t; int l, b; logic [W-1:0] rd; logic ok;
        fill_regs();
        run_cmd(1'b1, 1'b0, 2'b10, 2'b00, N'($urandom), '0, W'($urandom), '0, g, l, r, rd, e, b, t);
        for (int a = 1; a < DEPTH; a++) mdl[a] = '0;
        ok = (we_addr_q.size() == DEPTH - 1);
        if (ok) for (int i = 0; i < DEPTH - 1; i++)
            ok = ok && (we_addr_q[i] == N'(i + 1)) && (we_data_q[i] == '0) && (we_k_q[i] == i + 1);
        n_checks++; if (!ok) begin n_errors++; $display("FAIL clr_sweep: got %0d writes exp %0d consecutive addr 1..%0d data 0", we_addr_q.size(), DEPTH-1, DEPTH-1); end
        n_checks++; if (b !== DEPTH) begin n_errors++; $display("FAIL clr_busy: got %0d cycles exp %0d", b, DEPTH); end
        n_checks++; if (l !== DEPTH || e !== 1'b0 || rd !== '0) begin n_errors++; $display("FAIL clr_resp: got lat=%0d err=%b data=%h exp lat=%0d err=0 data=0", l, e, rd, DEPTH); end
        for (int a = 1; a < DEPTH; a++) begin
            run_cmd(1'b0, 1'b1, 2'b00, 2'b01, '0, N'(a), '0, '0, g, l, r, rd, e, b, t);
            n_checks++; if (rd !== '0) begin n_errors++; $display("FAIL clr_read[%0d]: got %h exp 0", a, rd); end
        end
    endtask

    task automatic test_round_robin();
        logic g, r, e, t; int l, b; logic [W-1:0] rd; logic [N-1:0] a0, a1; logic eg;
        do_reset();
        for (int i = 0; i < 4; i++) begin
            a0 = N'($urandom); a1 = N'($urandom);
            eg = ~exp_last;
            exp_last = eg;
            run_cmd(1'b1, 1'b1, 2'b01, 2'b01, a0, a1, '0, '0, g, l, r, rd, e, b, t);
            n_checks++; if (g !== eg || r !== eg) begin n_errors++; $display("FAIL rr_grant[%0d]: got grant=%b id=%b exp %b", i, g, r, eg); end
            n_checks++; if (rd !== mdl[eg ? a1 : a0]) begin n_errors++; $display("FAIL rr_data[%0d]: got %h exp %h", i, rd, mdl[eg ? a1 : a0]); end
        end
    endtask

    task automatic test_reset_sweep();
        logic g, r, e, t; int l, b; logic [W-1:0] rd; logic ok;
        fill_regs();
        @(negedge clk);
        req0_valid = 1'b1; req0_op = 2'b10; req0_addr = '0;
        #1;
        n_checks++; if (req0_ready !== 1'b1) begin n_errors++; $display("FAIL abort_hs: got ready=%b exp 1", req0_ready); end
        @(negedge clk);
        req0_valid = 1'b0;
        repeat (4) @(negedge clk);
        #1;
        n_checks++; if (rf_we !== 1'b1 || rf_addr_rd !== N'(5)) begin n_errors++; $display("FAIL abort_cyc5: got we=%b addr=%h exp we=1 addr=5", rf_we, rf_addr_rd); end
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        exp_last = 1'b1;
        #1;
        n_checks++; if (rf_we !== 1'b0 || busy !== 1'b0 || resp_valid !== 1'b0) begin n_errors++;
            $display("FAIL abort_after: got we=%b busy=%b resp=%b exp 0 0 0", rf_we, busy, resp_valid); end
        ok = 1'b1;
        for (int i = 0; i < 20; i++) begin
            @(negedge clk); #1;
            if (resp_valid || rf_we) ok = 1'b0;
        end
        n_checks++; if (!ok) begin n_errors++; $display("FAIL abort_quiet: got activity after abort exp none"); end
        for (int a = 1; a <= 5; a++) mdl[a] = '0;
        ok = 1'b1;
        for (int a = 0; a < DEPTH; a++) if (rf_mem[a] !== mdl[a]) ok = 1'b0;
        n_checks++; if (!ok) begin n_errors++; $display("FAIL abort_regs: got partial sweep differs from regs 1..5 cleared only"); end
        run_cmd(1'b1, 1'b1, 2'b01, 2'b01, N'(7), N'(9), '0, '0, g, l, r, rd, e, b, t);
        exp_last = 1'b0;
        n_checks++; if (g !== 1'b0 || rd !== mdl[7]) begin n_errors++; $display("FAIL abort_tie: got grant=%b data=%h exp grant=0 data=%h", g, rd, mdl[7]); end
    endtask

    task automatic test_random();
        logic g, r, e, t; int l, b; logic [W-1:0] rd; logic ok;
        logic [1:0] op [2]; logic [N-1:0] ad [2]; logic [W-1:0] dt [2];
        logic v0, v1, eg, eerr; logic [1:0] eop; logic [N-1:0] ea; logic [W-1:0] ed, erd;
        int vv, elat, ewe;
        do_reset();
        for (int n = 0; n < 40; n++) begin
            vv = $urandom_range(1, 3);
            v0 = vv[0]; v1 = vv[1];
            for (int q = 0; q < 2; q++) begin
                op[q] = ($urandom_range(0, 7) == 0) ? 2'b10 : 2'($urandom_range(0, 3));
                if (op[q] == 2'b10 && $urandom_range(0, 1) == 0) op[q] = 2'b00;
                ad[q] = ($urandom_range(0, 7) == 0) ? '0 : N'($urandom);
                dt[q] = W'($urandom);
            end
            eg = (v0 && v1) ? ~exp_last : v1;
            exp_last = eg;
            eop = op[eg]; ea = ad[eg]; ed = dt[eg];
            elat = (eop == 2'b10) ? DEPTH : 2;
            eerr = (eop == 2'b11) || (eop == 2'b00 && ea == '0);
            erd  = (eop == 2'b01) ? mdl[ea] : '0;
            ewe  = (eop == 2'b10) ? DEPTH - 1 : ((eop == 2'b00 && ea != '0) ? 1 : 0);
            run_cmd(v0, v1, op[0], op[1], ad[0], ad[1], dt[0], dt[1], g, l, r, rd, e, b, t);
            if (eop == 2'b00 && ea != '0) mdl[ea] = ed;
            if (eop == 2'b10) for (int a = 1; a < DEPTH; a++) mdl[a] = '0;
            n_checks++; if (g !== eg || r !== eg) begin n_errors++; $display("FAIL rnd_grant[%0d]: got grant=%b id=%b exp %b", n, g, r, eg); end
            n_checks++; if (l !== elat || b !== elat) begin n_errors++; $display("FAIL rnd_latency[%0d]: got lat=%0d busy=%0d exp %0d", n, l, b, elat); end
            n_checks++; if (rd !== erd || e !== eerr) begin n_errors++; $display("FAIL rnd_resp[%0d]: got data=%h err=%b exp data=%h err=%b", n, rd, e, erd, eerr); end
            n_checks++; if (we_addr_q.size() != ewe || t !== 1'b1) begin n_errors++; $display("FAIL rnd_we_tail[%0d]: got writes=%0d tail=%b exp %0d 1", n, we_addr_q.size(), t, ewe); end
            ok = 1'b1;
            for (int a = 0; a < DEPTH; a++) if (rf_mem[a] !== mdl[a]) ok = 1'b0;
            n_checks++; if (!ok) begin n_errors++; $display("FAIL rnd_regs[%0d]: got register file differs from model exp match", n); end
        end
    endtask

    initial begin
        for (int a = 0; a < DEPTH; a++) begin rf_mem[a] = '0; mdl[a] = '0; end
        exp_last = 1'b1;
        test_reset();
        test_write_read();
        test_addr0();
        test_reserved();
        test_clear();
        test_round_robin();
        test_reset_sweep();
        test_random();
        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: got timeout exp completion");
        $fatal(1, "timeout");
    end

endmodule
`default_nettype wire
